// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and TX arbiter state encoding.
// Constants only; no timing or flow-control behaviour of its own.
package uart_pkg;

    localparam int UART_W = 8;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_SEND = 2'd1;
    localparam logic [1:0] ARB_GAP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ARB_IDLE,
        ST_SEND = ARB_SEND,
        ST_GAP  = ARB_GAP
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Purely combinational (0 cycles); no flow control.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          any
);

    logic [N-1:0] rot;
    logic [N-1:0] rot_pick;

    // Explicit compare instead of modulo so N need not be a power of two.
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return PW'(s);
    endfunction

    always_comb begin
        rot  = '0;
        pick = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[wrap(ptr, k)];
        end
        rot_pick = rot & (~rot + N'(1));
        for (int k = 0; k < N; k++) begin
            pick[wrap(ptr, k)] = rot_pick[k];
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter feeding the uart TX path; 1 cycle request-to-grant, strobe 1 cycle after accept.
// Back-pressure: req_ready held low while uart_tx_full; at most one byte every 2 cycles.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [UART_W*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    input  logic                      uart_tx_full,
    output logic                      uart_tx_start,
    output logic [UART_W-1:0]         uart_tx_data_in,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t        state;
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     cnt;
    logic              rel;

    logic [N_REQ-1:0]  pick;
    logic              pick_any;
    logic [PW-1:0]     g_idx;
    logic [PW-1:0]     nxt_ptr;
    logic [UART_W-1:0] g_data;
    logic              g_valid;
    logic              g_last;
    logic [CW-1:0]     cnt_inc;

    rr_pick #(.N(N_REQ)) u_pick (
        .req  (req_valid),
        .ptr  (ptr),
        .pick (pick),
        .any  (pick_any)
    );

    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_idx  = PW'(i);
                g_data = req_data[i*UART_W +: UART_W];
            end
        end
    end

    assign g_valid = |(grant & req_valid);
    assign g_last  = |(grant & req_last);
    assign cnt_inc = cnt + CW'(1);
    // Releasing owner drops to lowest priority for the next pick.
    assign nxt_ptr = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);

    assign req_ready = (state == ST_SEND && !uart_tx_full) ? (grant & req_valid) : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            grant           <= '0;
            ptr             <= '0;
            cnt             <= '0;
            rel             <= 1'b0;
            uart_tx_start   <= 1'b0;
            uart_tx_data_in <= '0;
        end else begin
            uart_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!g_valid) begin
                        grant <= '0;
                        ptr   <= nxt_ptr;
                        state <= ST_IDLE;
                    end else if (!uart_tx_full) begin
                        uart_tx_data_in <= g_data;
                        uart_tx_start   <= 1'b1;
                        cnt             <= cnt_inc;
                        rel             <= g_last || (cnt_inc == CW'(MAX_BURST));
                        state           <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (rel) begin
                        grant <= '0;
                        ptr   <= nxt_ptr;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_SEND;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: reset/grant vector table plus scoreboarded packet sequences.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         uart_tx_full;
    logic         uart_tx_start;
    logic [7:0]   uart_tx_data_in;
    logic [N-1:0] grant;
    logic         busy;

    uart_tx_arb #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .uart_tx_full    (uart_tx_full),
        .uart_tx_start   (uart_tx_start),
        .uart_tx_data_in (uart_tx_data_in),
        .grant           (grant),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid;
        logic         full;
        logic [N-1:0] exp_grant;
        logic [N-1:0] exp_ready;
        logic         exp_busy;
    } vec_t;

    vec_t        tbl [5];
    logic [7:0]  exp_rr [6];
    int          exp_rr_g [6];
    logic [7:0]  exp_bu [11];
    int          exp_bu_g [4];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  srcq [N][$];
    logic [11:0] sb [$];
    logic [7:0]  out_log [$];
    int          grant_log [$];
    int          strobe_cyc [$];
    int          cyc;
    logic        prev_start;
    logic [N-1:0] prev_grant;
    logic [N-1:0] acc;
    bit          use_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (use_q && srcq[i].size() > 0) begin
                e = srcq[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic cycle();
        logic [8:0]  e;
        logic [11:0] x;
        @(negedge clk);
        acc = req_ready;
        chk("ready_within_grant", 32'(req_ready & ~grant), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                e = srcq[i].pop_front();
                sb.push_back({4'(i), e[7:0]});
            end
        end
        if (uart_tx_start) begin
            chk("no_back_to_back_strobe", 32'(prev_start), 32'd0);
            out_log.push_back(uart_tx_data_in);
            strobe_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe: got byte %0h, expected no strobe", uart_tx_data_in);
            end else begin
                x = sb.pop_front();
                chk("strobe_byte", 32'(uart_tx_data_in), 32'(x[7:0]));
            end
        end
        prev_start = uart_tx_start;
        if (grant != '0 && prev_grant == '0) grant_log.push_back(oh2i(grant));
        prev_grant = grant;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        use_q        = 1'b0;
        uart_tx_full = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        sb.delete();
        out_log.delete();
        grant_log.delete();
        strobe_cyc.delete();
        drive_reqs();
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        prev_start = 1'b0;
        prev_grant = '0;
        cyc        = 0;
        use_q      = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int c = 0; c < budget && out_log.size() < n; c++) cycle();
    endtask

    initial begin
        tbl[0] = '{4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1};
        tbl[1] = '{4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1};
        tbl[2] = '{4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1};
        tbl[3] = '{4'b1100, 1'b1, 4'b0100, 4'b0000, 1'b1};
        tbl[4] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};
        exp_rr   = '{8'h10, 8'h20, 8'h30, 8'h11, 8'h21, 8'h31};
        exp_rr_g = '{0, 2, 3, 0, 2, 3};
        exp_bu   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hA0, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        exp_bu_g = '{0, 1, 0, 0};

        // Reset held with every requester valid
        rst_n        = 1'b0;
        use_q        = 1'b0;
        uart_tx_full = 1'b0;
        req_valid    = '1;
        req_last     = '1;
        req_data     = 32'h44332211;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_start", 32'(uart_tx_start), 32'd0);
        chk("reset_data", 32'(uart_tx_data_in), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("grant_after_reset", 32'(grant), 32'h1);

        // Vector table: first pick from ptr=0 and ready gating
        for (int v = 0; v < 5; v++) begin
            rst_n        = 1'b0;
            req_valid    = tbl[v].valid;
            uart_tx_full = tbl[v].full;
            req_last     = '1;
            #2;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_grant", v), 32'(grant), 32'(tbl[v].exp_grant));
            chk($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
            chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].exp_busy));
        end

        // Single packet from requester 1
        do_reset();
        srcq[1].push_back({1'b0, 8'h41});
        srcq[1].push_back({1'b0, 8'h42});
        srcq[1].push_back({1'b1, 8'h43});
        drive_reqs();
        run_until(3, 100);
        chk("single_count", 32'(out_log.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            chk("single_spacing1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);
            chk("single_spacing2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd2);
        end
        chk("single_grant_held", 32'(grant), 32'h2);
        cycle();
        chk("single_grant_clear", 32'(grant), 32'd0);
        chk("single_busy_clear", 32'(busy), 32'd0);

        // Round-robin across requesters 0, 2, 3
        do_reset();
        srcq[0].push_back({1'b1, 8'h10});
        srcq[0].push_back({1'b1, 8'h11});
        srcq[2].push_back({1'b1, 8'h20});
        srcq[2].push_back({1'b1, 8'h21});
        srcq[3].push_back({1'b1, 8'h30});
        srcq[3].push_back({1'b1, 8'h31});
        drive_reqs();
        run_until(6, 200);
        repeat (3) cycle();
        chk("rr_count", 32'(out_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++) chk($sformatf("rr_byte%0d", k), 32'(out_log[k]), 32'(exp_rr[k]));
        chk("rr_grants", 32'(grant_log.size()), 32'd6);
        for (int k = 0; k < 6 && k < grant_log.size(); k++) chk($sformatf("rr_grant%0d", k), 32'(grant_log[k]), 32'(exp_rr_g[k]));

        // Burst limit of 4 with a waiting requester
        do_reset();
        for (int k = 0; k < 10; k++) srcq[0].push_back({1'b0, 8'(k)});
        srcq[1].push_back({1'b1, 8'hA0});
        drive_reqs();
        run_until(11, 300);
        repeat (4) cycle();
        chk("burst_count", 32'(out_log.size()), 32'd11);
        for (int k = 0; k < 11 && k < out_log.size(); k++) chk($sformatf("burst_byte%0d", k), 32'(out_log[k]), 32'(exp_bu[k]));
        chk("burst_grants", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) chk($sformatf("burst_grant%0d", k), 32'(grant_log[k]), 32'(exp_bu_g[k]));
        chk("burst_idle", 32'(busy), 32'd0);

        // Back-pressure held for 20 cycles mid-packet
        do_reset();
        for (int k = 1; k <= 5; k++) srcq[2].push_back({(k == 5), 8'(8'h50 + k)});
        drive_reqs();
        run_until(2, 100);
        uart_tx_full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            chk("bp_ready", 32'(acc), 32'd0);
            chk("bp_strobe", 32'(uart_tx_start), 32'd0);
        end
        chk("bp_grant_held", 32'(grant), 32'h4);
        uart_tx_full = 1'b0;
        run_until(5, 100);
        repeat (3) cycle();
        chk("bp_count", 32'(out_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < out_log.size(); k++) chk($sformatf("bp_byte%0d", k), 32'(out_log[k]), 32'(8'h51 + k));
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset during the GAP cycle
        do_reset();
        srcq[3].push_back({1'b0, 8'h61});
        srcq[3].push_back({1'b1, 8'h62});
        drive_reqs();
        run_until(1, 100);
        chk("gap_start_before", 32'(uart_tx_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_start", 32'(uart_tx_start), 32'd0);
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_data", 32'(uart_tx_data_in), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
